// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Define HILO_FAST_MUL_EN for single-cycle MULT/MULTU.
module hilo_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] WD,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int DW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] raw_a_q, raw_a_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_p_q, neg_p_d;
  logic             neg_r_q, neg_r_d;

  logic             sgn_op, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_shl, div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] it_hi, it_lo;
  logic [DW-1:0]    prod_mag, prod;
  logic [WIDTH-1:0] quo, rem;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             fast_mul, last;

  assign sgn_op = ~op[0];
  assign sa     = sgn_op & SrcA[WIDTH-1];
  assign sb     = sgn_op & SrcB[WIDTH-1];
  assign mag_a  = sa ? -SrcA : SrcA;
  assign mag_b  = sb ? -SrcB : SrcB;

  // acc_lo holds multiplier bits or dividend bits being shifted out
  always_comb begin
    mul_sum = {1'b0, acc_hi_q}
            + (acc_lo_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});
    div_shl = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge  = div_shl >= {1'b0, dvs_q};
    div_sub = div_shl - {1'b0, dvs_q};
    if (is_div_q) begin
      it_hi = div_ge ? div_sub[WIDTH-1:0] : div_shl[WIDTH-1:0];
      it_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

`ifdef HILO_FAST_MUL_EN
  assign fast_mul = ~is_div_q;
  assign prod_mag = fast_mul ? DW'(dvs_q) * DW'(acc_lo_q)
                             : {it_hi, it_lo};
`else
  assign fast_mul = 1'b0;
  assign prod_mag = {it_hi, it_lo};
`endif

  assign last = fast_mul | (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    prod = neg_p_q ? -prod_mag : prod_mag;
    quo  = neg_p_q ? -it_lo : it_lo;
    rem  = neg_r_q ? -it_hi : it_hi;
    if (dvs_q == '0) begin
      quo = '1;
      rem = raw_a_q;
    end
    res_hi = is_div_q ? rem : prod[DW-1:WIDTH];
    res_lo = is_div_q ? quo : prod[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    dvs_d    = dvs_q;
    raw_a_d  = raw_a_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (state_q != S_CALC) begin
      if (hi_we) hi_d = WD;
      if (lo_we) lo_d = WD;
    end
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d  = S_CALC;
          cnt_d    = '0;
          is_div_d = op[1];
          neg_p_d  = sa ^ sb;
          neg_r_d  = sa;
          raw_a_d  = SrcA;
          acc_hi_d = '0;
          acc_lo_d = op[1] ? mag_a : mag_b;
          dvs_d    = op[1] ? mag_b : mag_a;
        end
      end
      S_CALC: begin
        if (last) begin
          state_d = S_DONE;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          acc_hi_d = it_hi;
          acc_lo_d = it_lo;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      dvs_q    <= '0;
      raw_a_q  <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      dvs_q    <= dvs_d;
      raw_a_q  <= raw_a_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q == S_CALC);
  assign done = (state_q == S_DONE);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed testbench for hilo_muldiv.
// Define HILO_FAST_MUL_EN to match a fast-multiply build.
module tb_hilo_muldiv;

  localparam int W = 32;
`ifdef HILO_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W;
`endif

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic         clk = 1'b0;
  logic         rst, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wd;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hilo_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .SrcA(a), .SrcB(b), .hi_we(hi_we), .lo_we(lo_we),
    .WD(wd), .busy(busy), .done(done), .HI(hi), .LO(lo)
  );

  task automatic launch(input logic [1:0] o,
                        input logic [W-1:0] x,
                        input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 00", {busy, done});
    end
    n_cmp++;
    if ({hi, lo} !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_hilo got %h want 0", {hi, lo});
    end
  endtask

  task automatic test_multu;
    int cyc;
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== MUL_LAT) begin
      n_bad++;
      $display("FAIL multu_lat got %0d want %0d", cyc, MUL_LAT);
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL multu_done got %b want 1", done);
    end
    n_cmp++;
    if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) begin
      n_bad++;
      $display("FAIL multu_res got %h want 00000001fffffffe", {hi, lo});
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL multu_done_pulse got %b want 0", done);
    end
  endtask

  task automatic test_mult;
    int cyc;
    launch(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(cyc);
    n_cmp++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      n_bad++;
      $display("FAIL mult_neg got %h want ffffffffffffffeb", {hi, lo});
    end
    launch(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_done(cyc);
    n_cmp++;
    if ({hi, lo} !== 64'h4000_0000_0000_0000) begin
      n_bad++;
      $display("FAIL mult_min got %h want 4000000000000000", {hi, lo});
    end
  endtask

  task automatic test_div;
    int cyc;
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== W) begin
      n_bad++;
      $display("FAIL div_lat got %0d want %0d", cyc, W);
    end
    n_cmp++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      n_bad++;
      $display("FAIL div_neg got %h want ffffffff_fffffffd", {hi, lo});
    end
    launch(OP_DIVU, 32'd100, 32'd7);
    wait_done(cyc);
    n_cmp++;
    if ({hi, lo} !== {32'd2, 32'd14}) begin
      n_bad++;
      $display("FAIL divu got %h want 00000002_0000000e", {hi, lo});
    end
  endtask

  task automatic test_div_edge;
    int cyc;
    launch(OP_DIVU, 32'h1234, 32'd0);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== W) begin
      n_bad++;
      $display("FAIL divz_lat got %0d want %0d", cyc, W);
    end
    n_cmp++;
    if ({hi, lo} !== {32'h1234, 32'hFFFF_FFFF}) begin
      n_bad++;
      $display("FAIL divz got %h want 00001234_ffffffff", {hi, lo});
    end
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    n_cmp++;
    if ({hi, lo} !== {32'h0, 32'h8000_0000}) begin
      n_bad++;
      $display("FAIL div_ovf got %h want 00000000_80000000", {hi, lo});
    end
  endtask

  task automatic test_busy_ignore;
    int cyc;
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    op = OP_MULTU; a = 32'd3; b = 32'd3;
    start = 1'b1; hi_we = 1'b1; wd = 32'h55;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0;
    wait_done(cyc);
    n_cmp++;
    if (cyc + 5 !== W) begin
      n_bad++;
      $display("FAIL ignore_lat got %0d want %0d", cyc + 5, W);
    end
    n_cmp++;
    if ({hi, lo} !== {32'd2, 32'd14}) begin
      n_bad++;
      $display("FAIL ignore_res got %h want 00000002_0000000e", {hi, lo});
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_noqueue got busy=%b want 0", busy);
    end
    hi_we = 1'b1; wd = 32'hAA;
    @(posedge clk);
    #1 hi_we = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({hi, lo} !== {32'hAA, 32'd14}) begin
      n_bad++;
      $display("FAIL mthi got %h want 000000aa_0000000e", {hi, lo});
    end
  endtask

  task automatic test_mt_with_start;
    int cyc;
    lo_we = 1'b1; wd = 32'h77;
    launch(OP_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    n_cmp++;
    if ({busy, lo} !== {1'b1, 32'h77}) begin
      n_bad++;
      $display("FAIL mtlo_start got %h want 1_00000077", {busy, lo});
    end
    wait_done(cyc);
    n_cmp++;
    if ({hi, lo} !== {32'd2, 32'd14} || cyc + 1 !== W) begin
      n_bad++;
      $display("FAIL mtlo_overwrite got %h/%0d want 00000002_0000000e/%0d",
               {hi, lo}, cyc + 1, W);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    launch(OP_DIVU, 32'd100, 32'd7);
    wait_done(cyc);
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_done got %b want 1", done);
    end
    launch(OP_MULTU, 32'd3, 32'd5);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== MUL_LAT) begin
      n_bad++;
      $display("FAIL b2b_lat got %0d want %0d", cyc, MUL_LAT);
    end
    n_cmp++;
    if ({done, hi, lo} !== {1'b1, 32'd0, 32'd15}) begin
      n_bad++;
      $display("FAIL b2b_res got %h want 1_00000000_0000000f",
               {done, hi, lo});
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL rstmid_flags got %b want 00", {busy, done});
    end
    n_cmp++;
    if ({hi, lo} !== 64'h0) begin
      n_bad++;
      $display("FAIL rstmid_hilo got %h want 0", {hi, lo});
    end
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    n_cmp++;
    if (pulses !== 0 || {hi, lo} !== 64'h0) begin
      n_bad++;
      $display("FAIL rstmid_after got pulses=%0d hilo=%h want 0/0",
               pulses, {hi, lo});
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wd = '0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_edge();
    test_busy_ignore();
    test_mt_with_start();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
